mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single cacheline-wide physical memory port between the instruction cache and the data cache of the pipelined RV32I core. It sits below both caches and above the cacheline adaptor. It accepts at most one outstanding transaction, locks the grant until memory responds, and routes the response to the owner.

## Interface
Parameters:
- LINE_W, 256: cacheline width in bits.
- ADDR_W, 32: address width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- i_read  in  1  icache line-read request, held until i_resp.
- i_address  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line data to icache.
- i_resp  out  1  icache transaction done.
- d_read  in  1  dcache line-read request, held until d_resp.
- d_write  in  1  dcache line-write request (writeback), held until d_resp.
- d_address  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache writeback data.
- d_rdata  out  LINE_W  line data to dcache.
- d_resp  out  1  dcache transaction done.
- pmem_read  out  1  memory line read.
- pmem_write  out  1  memory line write.
- pmem_address  out  ADDR_W  line address, bits [4:0] forced to 0.
- pmem_wdata  out  LINE_W  write data.
- pmem_rdata  in  LINE_W  read data.
- pmem_resp  in  1  memory done, one-cycle pulse.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: neither request -> stay. Only i_read -> SERVE_I. Only d_read|d_write -> SERVE_D. Both -> tie rule (see Configuration).
- On the grant edge, latch the owner's address, wdata, and op (read/write) into registers. pmem_* outputs are driven only from these registers, so a requester changing its inputs mid-transaction has no effect.
- SERVE_I: pmem_read=1. SERVE_D: pmem_read or pmem_write according to the latched op. The grant holds until pmem_resp, regardless of other requests.
- pmem_resp in SERVE_x: x_resp=1 combinationally in the same cycle. x_rdata=pmem_rdata (passthrough, valid only while x_resp). Next state is RELEASE.
- RELEASE: pmem_read=pmem_write=0 and requests are ignored. This gives the requester one cycle to drop its stale request. Next state is IDLE.
- d_read and d_write both high: illegal. The write wins. With simulation-only checks present, an assertion fires.
- pmem_resp in IDLE or RELEASE is ignored. No x_resp is generated.
- Non-owner x_resp is always 0. Non-owner x_rdata is don't-care; it is driven with pmem_rdata.

## Timing
- Reset values: state=IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0. Round-robin pointer last=I.
- Reset asserted mid-transaction: the block returns to IDLE immediately and asynchronously, and the memory strobes drop. The adaptor is reset by the same rst.
- Request first seen in IDLE at cycle N -> pmem strobe high from cycle N+1.
- pmem_resp at cycle M -> x_resp at M. Strobe low at M+1 (RELEASE). IDLE at M+2. The earliest next strobe is at M+3.
- Minimum occupancy per transaction is 3 cycles plus memory latency.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, grant the requester not granted last. The `last` register updates on each grant; its reset value is I, so the first tie goes to D.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, and D always wins ties. The `last` register is not present.
- Non-tie behaviour is identical in both builds.

## Structure
- Shared package arb_pkg:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, RELEASE}.
  - arb_owner_t enum {OWN_I, OWN_D}.
  - LINE_OFFSET_BITS=5 constant.
- Single flat module. No sub-module is natural, because the grant logic is a few lines inside the next-state block.

## Test plan
- Lone icache read: i_read=1, i_address=0x0000_1234, pmem_resp after 4 cycles with pmem_rdata=0xAA..AA -> pmem_address=0x0000_1220, i_resp for 1 cycle with i_rdata=0xAA..AA, d_resp stays 0.
- Lone dcache writeback: d_write=1, d_address=0x8000_0040, d_wdata=0x55..55 -> pmem_write=1 with matching address and data, d_resp on the pmem_resp cycle, pmem_write low the next cycle.
- Simultaneous i_read and d_read, two back-to-back rounds:
  - Without ARB_ROUND_ROBIN_EN -> D is served both rounds.
  - With the macro -> D, then I.
- Lock: grant D, then raise i_read and change d_address to 0xDEAD_0000 mid-transaction -> pmem_address stays at the original value and no switch occurs before pmem_resp. I is served starting 3 cycles after D's resp.
- Spurious and illegal inputs:
  - pmem_resp pulsed in IDLE -> no x_resp.
  - d_read=d_write=1 -> pmem_write=1 and the assertion fires.
- Reset mid-transaction: async rst in SERVE_I with i_read still high -> pmem_read=0 within the same cycle and all outputs at reset values. After rst drops, i_read is granted again with the strobe 1 cycle later.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for mem_arbiter: FSM states, owner tags and line geometry.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
  localparam int LINE_OFFSET_BITS = 5;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of mem_arbiter.
// slave: arbiter view. master: environment view (caches + memory).
interface mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter for the single cacheline memory port.
// One outstanding transaction; grant locked until pmem_resp, then one
// RELEASE cycle so the owner can drop its request.
// Optional feature: ARB_ROUND_ROBIN_EN selects round-robin on ties;
// otherwise D wins ties.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

  arb_state_t        state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              wr_q;
  logic              i_req, d_req, tie_d, gnt_i, gnt_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last;
  assign tie_d = (last == OWN_I);

  // Remember who was granted last so the next tie goes to the other side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          last <= OWN_I;
    else if (state == IDLE && gnt_d)  last <= OWN_D;
    else if (state == IDLE && gnt_i)  last <= OWN_I;
  end
`else
  assign tie_d = 1'b1;
`endif

  // Grant decision; only consulted in IDLE.
  assign gnt_d = d_req & (~i_req | tie_d);
  assign gnt_i = i_req & ~gnt_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and all cache/memory-facing outputs.
  always_comb begin
    nxt              = state;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = addr_q;
    bus.pmem_wdata   = wdata_q;
    bus.i_resp       = 1'b0;
    bus.d_resp       = 1'b0;
    bus.i_rdata      = bus.pmem_rdata;
    bus.d_rdata      = bus.pmem_rdata;
    case (state)
      IDLE: begin
        if (gnt_d)      nxt = SERVE_D;
        else if (gnt_i) nxt = SERVE_I;
      end
      SERVE_I: begin
        bus.pmem_read = 1'b1;
        bus.i_resp    = bus.pmem_resp;
        if (bus.pmem_resp) nxt = RELEASE;
      end
      SERVE_D: begin
        bus.pmem_read  = ~wr_q;
        bus.pmem_write = wr_q;
        bus.d_resp     = bus.pmem_resp;
        if (bus.pmem_resp) nxt = RELEASE;
      end
      RELEASE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Capture the winner's request on the grant edge; pmem_* come only from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (state == IDLE && gnt_d) begin
      addr_q  <= bus.d_address & ~OFF_MASK;
      wdata_q <= bus.d_wdata;
      wr_q    <= bus.d_write;
    end else if (state == IDLE && gnt_i) begin
      addr_q  <= bus.i_address & ~OFF_MASK;
      wr_q    <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Simultaneous dcache read and write is illegal; the write is served.
  always @(posedge clk) begin
    if (!rst)
      assert (!(bus.d_read && bus.d_write))
        else $warning("mem_arbiter: d_read and d_write both high, write wins");
  end
`endif

endmodule
